video_window_buffer: RTL
========================

VIDEO_WINDOW_BUFFER -- requirements
Module: video_window_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per colour channel.
REQ-002 SHALL have parameter CH, default 3, channels per pixel (in_data channel k at bits [k*DATA_W +: DATA_W]).
REQ-003 SHALL have parameter KSIZE, default 3, window edge; legal values 3 and 5.
REQ-004 SHALL have parameter MAX_W, default 2048, maximum active pixels per line.
REQ-005 SHALL have parameter BORDER, default 0; 0 = zero-fill invalid taps, 1 = replicate nearest valid tap.
REQ-006 SHALL have ports, clock and reset first:
 clk  in  1  pixel clock, all logic on rising edge
 rst  in  1  synchronous, active-low reset
 in_data  in  CH*DATA_W  input pixel
 in_dv  in  1  active-video strobe
 in_hs  in  1  horizontal sync
 in_vs  in  1  vertical sync
 bypass  in  1  every tap = newest pixel
 out_win  out  KSIZE*KSIZE*CH*DATA_W  window taps
 out_dv  out  1  delayed in_dv
 out_hs  out  1  delayed in_hs
 out_vs  out  1  delayed in_vs
 out_line_len  out  clog2(MAX_W+1)  length of last completed line
 out_overflow  out  1  sticky line-too-long flag
REQ-007 Tap t = r*KSIZE + c SHALL occupy out_win[t*CH*DATA_W +: CH*DATA_W]; r = lines above current (0 = current), c = pixels back (0 = newest).

Function
REQ-008 out_dv/out_hs/out_vs SHALL equal in_dv/in_hs/in_vs delayed exactly 3 clk cycles; out_win SHALL be aligned with out_dv.
REQ-009 Column counter x SHALL count in_dv-high cycles within a line, starting at 0; SHALL clear on the cycle after in_dv falls.
REQ-010 On in_dv falling edge, out_line_len SHALL load x (pixel count) and line counter y SHALL increment, saturating at KSIZE-1.
REQ-011 y SHALL clear on in_vs rising edge; simultaneous in_vs rise and in_dv fall SHALL clear y (clear wins) while still loading out_line_len.
REQ-012 KSIZE-1 line buffers, each MAX_W deep x CH*DATA_W wide, SHALL be addressed by x, read-before-write; buffer 0 stores in_data, buffer i stores data read from buffer i-1.
REQ-013 Line buffers SHALL be written only when in_dv=1 and x < MAX_W; contents SHALL NOT be cleared by reset or vs.
REQ-014 Window shift register SHALL advance only on in_dv-aligned cycles; it SHALL hold when dv is low.
REQ-015 Tap (r,c) SHALL be valid iff r <= y and c <= x of the newest pixel and x < MAX_W.
REQ-016 BORDER=0: invalid taps SHALL output all zeros.
REQ-017 BORDER=1: invalid tap SHALL output the valid tap with largest r' <= r in same column, then largest c' <= c in same row; tap (0,0) always valid when x < MAX_W.
REQ-018 Pixels with x >= MAX_W SHALL not be stored, all their taps SHALL be zero, out_overflow SHALL set and remain set until reset.
REQ-019 bypass=1 SHALL drive every tap with tap (0,0) data; latency, counters and buffer writes unchanged; bypass sampled with in_dv (same 3-cycle alignment).
REQ-020 When out_dv=0, out_win SHALL hold its last value.

Reset
REQ-021 rst=0 at a clk edge SHALL zero x, y, out_win, out_dv, out_hs, out_vs, out_line_len, out_overflow and the 3-cycle delay pipeline.
REQ-022 Reset asserted mid-line SHALL discard the partial line; first line after release SHALL be treated as y=0 (rows above invalid).

Verification
REQ-023 DATA_W=8,CH=1,KSIZE=3,BORDER=0; two lines of 4 pixels, line0=1,2,3,4, line1=5,6,7,8 -> at line1 pixel 8: taps (0,0..2)=8,7,6, (1,0..2)=4,3,2, row 2 = 0; out_line_len=4.
REQ-024 Same stimulus, BORDER=1 -> line0 pixel 1: all 9 taps =1; line1 pixel 5: row0=5,5,5, rows1-2=1,1,1.
REQ-025 Single dv pulse with hs/vs toggles -> out_dv/out_hs/out_vs identical waveforms shifted exactly 3 cycles.
REQ-026 MAX_W=4, 6-pixel line -> out_overflow=1 from pixel index 4, taps zero for pixels 4-5, out_line_len=6 after line end; stays 1 until rst=0.
REQ-027 vs rise then 3 lines of value 9 with KSIZE=5,BORDER=0 -> third line rows 3-4 zero, rows 0-2 nonzero where c<=x.
REQ-028 rst=0 for one cycle mid-line, then new line of value 3 -> all outputs zero during reset, next line rows 1-2 zero (BORDER=0), bypass=1 line gives all taps=3.

Source files
------------

// File: rtl/video_window_buffer.sv
// Sliding KSIZE x KSIZE pixel window over a raster stream, built from KSIZE-1 line buffers
// and a shift register, with border handling, bypass and a fixed 3-cycle latency.
module video_window_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH     = 3,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned MAX_W  = 2048,
  parameter int unsigned BORDER = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CH*DATA_W-1:0]               in_data,
  input  logic                               in_dv,
  input  logic                               in_hs,
  input  logic                               in_vs,
  input  logic                               bypass,
  output logic [KSIZE*KSIZE*CH*DATA_W-1:0]   out_win,
  output logic                               out_dv,
  output logic                               out_hs,
  output logic                               out_vs,
  output logic [$clog2(MAX_W+1)-1:0]         out_line_len,
  output logic                               out_overflow
);

  localparam int unsigned PIX_W  = CH * DATA_W;
  localparam int unsigned LEN_W  = $clog2(MAX_W + 1);
  localparam int unsigned ADDR_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned IDX_W  = $clog2(KSIZE);
  localparam int unsigned NBUF   = KSIZE - 1;
  localparam int unsigned WIN_W  = KSIZE * KSIZE * PIX_W;

  logic [LEN_W-1:0]  x;
  logic [IDX_W-1:0]  y;
  logic              in_range_c;
  logic [ADDR_W-1:0] addr_c;
  logic [IDX_W-1:0]  xc_c;

  logic [PIX_W-1:0]  line_mem [NBUF][MAX_W];

  logic              dv1, hs1, vs1, byp1, ovf1;
  logic [IDX_W-1:0]  y1, xc1;
  logic [PIX_W-1:0]  col1 [KSIZE];

  logic              dv2, hs2, vs2, byp2, ovf2;
  logic [IDX_W-1:0]  y2, xc2;
  logic [PIX_W-1:0]  win [KSIZE][KSIZE];

  logic [WIN_W-1:0]  taps_c;
  logic [IDX_W-1:0]  r_sel_c, c_sel_c;
  logic [PIX_W-1:0]  tap_c;

  assign in_range_c = (x < LEN_W'(MAX_W));
  assign addr_c     = ADDR_W'(x);
  // Column index clamped to the window edge; only c <= x matters for validity.
  assign xc_c       = (x >= LEN_W'(KSIZE - 1)) ? IDX_W'(KSIZE - 1) : IDX_W'(x);

  // Column / line counters and last-line length.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x            <= '0;
      y            <= '0;
      out_line_len <= '0;
    end else begin
      if (in_dv) begin
        if (x != '1) x <= x + LEN_W'(1);
      end else begin
        x <= '0;
      end
      if (dv1 && !in_dv) out_line_len <= x;
      if (in_vs && !vs1) y <= '0;
      else if (dv1 && !in_dv && y != IDX_W'(KSIZE - 1)) y <= y + IDX_W'(1);
    end
  end

  // Line buffers cascade: each one hands its old contents to the next (read-before-write).
  always_ff @(posedge clk) begin
    if (rst && in_dv && in_range_c) begin
      line_mem[0][addr_c] <= in_data;
      for (int i = 1; i < NBUF; i++) line_mem[i][addr_c] <= line_mem[i-1][addr_c];
    end
  end

  // Stage 1: fetch the new column and capture per-pixel context.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dv1 <= 1'b0; hs1 <= 1'b0; vs1 <= 1'b0; byp1 <= 1'b0; ovf1 <= 1'b0;
      y1  <= '0;   xc1 <= '0;
      for (int i = 0; i < KSIZE; i++) col1[i] <= '0;
    end else begin
      dv1 <= in_dv; hs1 <= in_hs; vs1 <= in_vs;
      if (in_dv) begin
        byp1    <= bypass;
        ovf1    <= !in_range_c;
        y1      <= y;
        xc1     <= xc_c;
        col1[0] <= in_data;
        for (int i = 1; i < KSIZE; i++) col1[i] <= in_range_c ? line_mem[i-1][addr_c] : '0;
      end
    end
  end

  // Stage 2: window shift register, advancing only on valid pixels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dv2 <= 1'b0; hs2 <= 1'b0; vs2 <= 1'b0; byp2 <= 1'b0; ovf2 <= 1'b0;
      y2  <= '0;   xc2 <= '0;
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++) win[r][c] <= '0;
    end else begin
      dv2 <= dv1; hs2 <= hs1; vs2 <= vs1;
      if (dv1) begin
        byp2 <= byp1;
        ovf2 <= ovf1;
        y2   <= y1;
        xc2  <= xc1;
        for (int r = 0; r < KSIZE; r++) begin
          win[r][0] <= col1[r];
          for (int c = 1; c < KSIZE; c++) win[r][c] <= win[r][c-1];
        end
      end
    end
  end

  // Tap selection: clamp (r,c) to the nearest valid tap, then apply border/bypass/overflow.
  always_comb begin
    taps_c  = '0;
    r_sel_c = '0;
    c_sel_c = '0;
    tap_c   = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        r_sel_c = (IDX_W'(r) > y2)  ? y2  : IDX_W'(r);
        c_sel_c = (IDX_W'(c) > xc2) ? xc2 : IDX_W'(c);
        if (ovf2)                                              tap_c = '0;
        else if (byp2)                                         tap_c = win[0][0];
        else if (r_sel_c == IDX_W'(r) && c_sel_c == IDX_W'(c)) tap_c = win[r][c];
        else if (BORDER == 1)                                  tap_c = win[r_sel_c][c_sel_c];
        else                                                   tap_c = '0;
        taps_c[(r*KSIZE + c)*PIX_W +: PIX_W] = tap_c;
      end
    end
  end

  // Stage 3: registered outputs; window and overflow only update on valid pixels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_dv       <= 1'b0;
      out_hs       <= 1'b0;
      out_vs       <= 1'b0;
      out_win      <= '0;
      out_overflow <= 1'b0;
    end else begin
      out_dv <= dv2;
      out_hs <= hs2;
      out_vs <= vs2;
      if (dv2) begin
        out_win <= taps_c;
        if (ovf2) out_overflow <= 1'b1;
      end
    end
  end

endmodule
